// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for the shared uart_tx arbiter.
// Producers drive req/data; the arbiter returns ack/sent pulses.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
   logic [NUM_REQ-1:0]            o_ack;
   logic [NUM_REQ-1:0]            o_sent;

   modport master (
      output i_req,
      output i_data,
      input  o_ack,
      input  o_sent
   );

   modport slave (
      input  i_req,
      input  i_data,
      output o_ack,
      output o_sent
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between byte producers.
// Adds a tick-timed idle gap after frames and a done watchdog.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int GAP_TICKS     = 16,
   parameter int TIMEOUT_TICKS = 200,
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_ticks,
   uart_tx_arbiter_if.slave      rq,
   input  logic                  i_tx_done,
   output logic                  o_err,
   output logic                  o_busy,
   output logic [GW-1:0]         o_grant_id,
   output logic                  o_tx_signal,
   output logic [DATA_WIDTH-1:0] o_data_byte
);

   localparam logic [15:0] GAP_L =
      (GAP_TICKS > 65535) ? 16'hFFFF : 16'(GAP_TICKS);
   localparam logic [15:0] TO_L =
      (TIMEOUT_TICKS > 65535) ? 16'hFFFF : 16'(TIMEOUT_TICKS);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      GAP
   } state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         ptr_q, ptr_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [DATA_WIDTH-1:0] byte_q, byte_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic [NUM_REQ-1:0]    sent_q, sent_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic                  tx_q, tx_d;
   logic [15:0]           wd_q, wd_d;
   logic [15:0]           gap_q, gap_d;

   logic                  found_hi;
   logic [GW-1:0]         win_hi, win_lo, win;
   logic [GW-1:0]         ptr_nx;
   logic [DATA_WIDTH-1:0] win_byte;
   logic [NUM_REQ-1:0]    win_hot;
   logic [NUM_REQ-1:0]    grant_hot;

   // Pick the lowest requester at or above the pointer, else wrap low.
   always_comb begin
      found_hi = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rq.i_req[j]) begin
            if (j >= int'(ptr_q)) begin
               found_hi = 1'b1;
               win_hi   = GW'(j);
            end else begin
               win_lo = GW'(j);
            end
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   // Decode the winner into byte, one-hot and the advanced pointer.
   always_comb begin
      win_byte  = '0;
      win_hot   = '0;
      grant_hot = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win == GW'(j)) begin
            win_byte = rq.i_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
         win_hot[j]   = (win == GW'(j));
         grant_hot[j] = (grant_q == GW'(j));
      end
      if (win == GW'(NUM_REQ - 1)) begin
         ptr_nx = '0;
      end else begin
         ptr_nx = win + GW'(1);
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      byte_d  = byte_q;
      ack_d   = '0;
      sent_d  = '0;
      err_d   = 1'b0;
      tx_d    = 1'b0;
      wd_d    = wd_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (|rq.i_req) begin
               state_d = START;
               ptr_d   = ptr_nx;
               grant_d = win;
               byte_d  = win_byte;
               ack_d   = win_hot;
            end
         end
         START: begin
            tx_d    = 1'b1;
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (i_ticks && wd_q != 16'hFFFF) begin
               wd_d = wd_q + 16'd1;
            end
            if (i_tx_done) begin
               sent_d  = grant_hot;
               gap_d   = GAP_L;
               state_d = (GAP_L == 16'd0) ? IDLE : GAP;
            end else if (wd_d >= TO_L) begin
               err_d   = 1'b1;
               gap_d   = GAP_L;
               state_d = (GAP_L == 16'd0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (i_ticks && gap_q != 16'd0) begin
               gap_d = gap_q - 16'd1;
            end
            if (gap_d == 16'd0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset drops any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         byte_q  <= '0;
         ack_q   <= '0;
         sent_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         tx_q    <= 1'b0;
         wd_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         byte_q  <= byte_d;
         ack_q   <= ack_d;
         sent_q  <= sent_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         tx_q    <= tx_d;
         wd_q    <= wd_d;
         gap_q   <= gap_d;
      end
   end

   assign rq.o_ack    = ack_q;
   assign rq.o_sent   = sent_q;
   assign o_err       = err_q;
   assign o_busy      = busy_q;
   assign o_grant_id  = grant_q;
   assign o_tx_signal = tx_q;
   assign o_data_byte = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with three requesters.
// Vector table, hand sequences and a random run against a frame model.
module tb_uart_tx_arbiter;

   localparam int N   = 3;
   localparam int GAP = 16;
   localparam int TO  = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        ticks;
   logic        done;
   logic        err;
   logic        busy;
   logic [1:0]  gid;
   logic        tx;
   logic [7:0]  dbyte;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(8)) rq ();

   uart_tx_arbiter #(
      .NUM_REQ(N),
      .DATA_WIDTH(8),
      .GAP_TICKS(GAP),
      .TIMEOUT_TICKS(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_ticks(ticks),
      .rq(rq),
      .i_tx_done(done),
      .o_err(err),
      .o_busy(busy),
      .o_grant_id(gid),
      .o_tx_signal(tx),
      .o_data_byte(dbyte)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [23:0] data;
      int          lat;
      int          w;
      logic [7:0]  b;
      bit          ok;
   } vec_t;

   vec_t vecs [14];

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // frame model
   bit         m_free = 1'b1;
   bit         m_pend = 1'b0;
   bit         m_line = 1'b0;
   int         m_wd = 0;
   int         m_quiet = 0;
   int         m_ptr = 0;
   logic [1:0] e_grant = '0;
   logic [7:0] e_byte = '0;

   // tick and done drivers
   bit tick_rand = 1'b0;
   bit stray = 1'b0;
   bit dn_on = 1'b0;
   int dn_cnt = 0;
   int dn_lat = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(logic [2:0] r, int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return 0;
   endfunction

   task automatic cyc();
      logic [2:0] ea;
      logic [2:0] es;
      logic       ee;
      logic       et;
      int         w;
      ea = '0;
      es = '0;
      ee = 1'b0;
      et = 1'b0;
      @(posedge clk);
      #1;
      edge_n++;
      if (reset) begin
         m_free = 1'b1;
         m_pend = 1'b0;
         m_line = 1'b0;
         m_quiet = 0;
         m_ptr = 0;
         e_grant = '0;
         e_byte = '0;
         dn_on = 1'b0;
      end else if (m_pend) begin
         et = 1'b1;
         m_pend = 1'b0;
         m_line = 1'b1;
         m_wd = 0;
      end else if (m_line) begin
         m_wd += int'(ticks);
         if (done) begin
            es[e_grant] = 1'b1;
            m_line = 1'b0;
         end else if (m_wd >= TO) begin
            ee = 1'b1;
            m_line = 1'b0;
         end
         if (!m_line) begin
            m_quiet = GAP;
            m_free = (GAP == 0);
         end
      end else if (!m_free) begin
         if (ticks) m_quiet--;
         if (m_quiet == 0) m_free = 1'b1;
      end else if (rq.i_req != 3'b000) begin
         w = rr_pick(rq.i_req, m_ptr);
         ea[w] = 1'b1;
         e_grant = 2'(w);
         e_byte = rq.i_data[w*8 +: 8];
         m_ptr = (w + 1) % N;
         m_free = 1'b0;
         m_pend = 1'b1;
      end
      check("cycle",
            64'({rq.o_ack, rq.o_sent, err, busy, gid, tx, dbyte}),
            64'({ea, es, ee, !m_free, e_grant, et, e_byte}));
      if (rq.o_sent != 3'b000 || err) dn_on = 1'b0;
      if (tx) begin
         dn_on = 1'b1;
         dn_cnt = 0;
      end
      if (tick_rand) ticks = 1'($urandom_range(1, 0));
      else ticks = (edge_n % 3 == 0);
      done = 1'b0;
      if (dn_on && ticks) begin
         dn_cnt++;
         if (dn_lat != 0 && dn_cnt == dn_lat) begin
            done = 1'b1;
            dn_on = 1'b0;
         end
      end
      if (stray && $urandom_range(63, 0) == 0) done = 1'b1;
   endtask

   task automatic serve(vec_t v);
      bit got;
      int cnt;
      int gcnt;
      rq.i_req = v.req;
      rq.i_data = v.data;
      dn_lat = v.lat;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc();
         if (rq.o_ack != 3'b000) got = 1'b1;
      end
      if (!got) begin
         check("ack_wait", 64'(0), 64'(1));
         rq.i_req = '0;
         return;
      end
      check("ack", 64'(rq.o_ack), 64'(3'b001 << v.w));
      check("grant", 64'(gid), 64'(v.w));
      check("byte", 64'(dbyte), 64'(v.b));
      rq.i_req = '0;
      rq.i_data = 24'($urandom);
      cyc();
      check("tx_start", 64'(tx), 64'(1));
      cnt = ticks ? 1 : 0;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         cyc();
         if (rq.o_sent != 3'b000 || err) got = 1'b1;
         else if (ticks) cnt++;
      end
      if (!got) begin
         check("result_wait", 64'(0), 64'(1));
         return;
      end
      check("outcome", 64'({rq.o_sent, err}),
            64'(v.ok ? {(3'b001 << v.w), 1'b0} : 4'b0001));
      check("line_ticks", 64'(cnt), 64'(v.ok ? v.lat : TO));
      gcnt = ticks ? 1 : 0;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         cyc();
         if (!busy) got = 1'b1;
         else if (ticks) gcnt++;
      end
      if (!got) begin
         check("idle_wait", 64'(0), 64'(1));
         return;
      end
      check("gap_ticks", 64'(gcnt), 64'(GAP));
   endtask

   initial begin
      vec_t v;
      bit   got;
      vecs[0]  = '{3'b001, 24'h00002F, 12,  0, 8'h2F, 1'b1};
      vecs[1]  = '{3'b011, 24'h003CA5, 12,  1, 8'h3C, 1'b1};
      vecs[2]  = '{3'b011, 24'h003CA5, 30,  0, 8'hA5, 1'b1};
      vecs[3]  = '{3'b011, 24'h003CA5, 7,   1, 8'h3C, 1'b1};
      vecs[4]  = '{3'b011, 24'h003CA5, 9,   0, 8'hA5, 1'b1};
      vecs[5]  = '{3'b100, 24'h770000, 4,   2, 8'h77, 1'b1};
      vecs[6]  = '{3'b111, 24'h332211, 3,   0, 8'h11, 1'b1};
      vecs[7]  = '{3'b111, 24'h332211, 3,   1, 8'h22, 1'b1};
      vecs[8]  = '{3'b111, 24'h332211, 3,   2, 8'h33, 1'b1};
      vecs[9]  = '{3'b110, 24'h665544, 0,   1, 8'h55, 1'b0};
      vecs[10] = '{3'b101, 24'h998877, 200, 2, 8'h99, 1'b1};
      vecs[11] = '{3'b010, 24'h00BB00, 201, 1, 8'hBB, 1'b0};
      vecs[12] = '{3'b001, 24'h0000CD, 199, 0, 8'hCD, 1'b1};
      vecs[13] = '{3'b110, 24'hE2E100, 5,   1, 8'hE1, 1'b1};

      reset = 1'b1;
      ticks = 1'b0;
      done = 1'b0;
      rq.i_req = '0;
      rq.i_data = '0;
      cyc();
      cyc();
      check("reset_state",
            64'({rq.o_ack, rq.o_sent, err, busy, gid, tx, dbyte}),
            64'(0));
      reset = 1'b0;
      cyc();

      for (int i = 0; i < 14; i++) begin
         serve(vecs[i]);
      end

      // reset while waiting on a frame that never completes
      rq.i_req = 3'b001;
      rq.i_data = 24'h00005A;
      dn_lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc();
         if (tx) got = 1'b1;
         if (rq.o_ack != 3'b000) rq.i_req = '0;
      end
      check("mid_tx_seen", 64'(got), 64'(1));
      rq.i_req = '0;
      for (int i = 0; i < 12; i++) cyc();
      check("mid_busy", 64'(busy), 64'(1));
      reset = 1'b1;
      cyc();
      check("mid_reset",
            64'({rq.o_ack, rq.o_sent, err, busy, gid, tx, dbyte}),
            64'(0));
      reset = 1'b0;
      v = '{3'b011, 24'h00B2B1, 6, 0, 8'hB1, 1'b1};
      serve(v);
      v = '{3'b010, 24'h00C2C1, 8, 1, 8'hC2, 1'b1};
      serve(v);

      // random traffic, random tick spacing and stray done pulses
      tick_rand = 1'b1;
      stray = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         cyc();
         reset = (c == 3000);
         for (int k = 0; k < N; k++) begin
            if (rq.i_req[k]) begin
               if (rq.o_ack[k]) begin
                  rq.i_req[k] = 1'b0;
                  rq.i_data[k*8 +: 8] = 8'($urandom);
               end else if ($urandom_range(99, 0) == 0) begin
                  rq.i_req[k] = 1'b0;
               end
            end else if ($urandom_range(15, 0) == 0) begin
               rq.i_req[k] = 1'b1;
               rq.i_data[k*8 +: 8] = 8'($urandom);
            end
         end
         if (rq.o_ack != 3'b000) begin
            case ($urandom_range(9, 0))
               0, 1, 2, 3, 4, 5: dn_lat = int'($urandom_range(50, 1));
               6, 7, 8: dn_lat = int'($urandom_range(205, 195));
               default: dn_lat = 0;
            endcase
         end
      end
      reset = 1'b0;
      rq.i_req = '0;
      for (int i = 0; i < 10; i++) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
